// File: rtl/am_lock_lane_rx_pkg.sv
// Shared constants for 40GBASE-R alignment-marker handling: sync headers,
// per-lane AM byte encodings and the AM lock FSM state type.
package pcs_am_pkg;

  localparam int BLOCK_W_DEF = 66;
  localparam int LANE_N_DEF  = 4;

  localparam logic [1:0] SH_DATA = 2'b10;
  localparam logic [1:0] SH_CTRL = 2'b01;

  // {M2,M1,M0} per lane, laid out exactly as they sit in block[25:2]
  localparam logic [LANE_N_DEF-1:0][23:0] AM_ENC = {
    24'h3D79A2,  // lane 3
    24'h9B65C5,  // lane 2
    24'hE6C4F0,  // lane 1
    24'h477690   // lane 0
  };

  typedef enum logic [1:0] {
    FIND,
    WAIT,
    LOCK
  } state_t;

endpackage

// File: rtl/am_lock_lane_rx_if.sv
// Block stream in / registered block stream plus AM lock status out.
interface am_lock_lane_rx_if
  import pcs_am_pkg::*;
#(
  parameter int BLOCK_W = BLOCK_W_DEF,
  parameter int LANE_W  = 2
);
  logic               block_v_i;
  logic               block_lock_i;
  logic [BLOCK_W-1:0] data_i;
  logic               data_v_o;
  logic [BLOCK_W-1:0] data_o;
  logic               am_v_o;
  logic               am_lock_o;
  logic [LANE_W-1:0]  lane_o;

  modport master (
    output block_v_i, block_lock_i, data_i,
    input  data_v_o, data_o, am_v_o, am_lock_o, lane_o
  );

  modport slave (
    input  block_v_i, block_lock_i, data_i,
    output data_v_o, data_o, am_v_o, am_lock_o, lane_o
  );
endinterface

// File: rtl/am_lock_lane_rx_match.sv
// Combinational AM detector: control header, M0-M2 equal to a lane encoding
// and M4-M6 equal to their complements. BIP3/BIP7 are not inspected.
module am_match_rx
  import pcs_am_pkg::*;
#(
  parameter int BLOCK_W = BLOCK_W_DEF,
  parameter int LANE_N  = LANE_N_DEF,
  parameter int LANE_W  = $clog2(LANE_N)
) (
  input  logic [BLOCK_W-1:0] blk,
  output logic               hit,
  output logic [LANE_W-1:0]  hit_lane
);

  logic [LANE_N-1:0] lane_hit;
  logic              ctrl;
  logic              unused_bip;

  assign ctrl       = (blk[1:0] == SH_CTRL);
  assign unused_bip = ^{blk[BLOCK_W-1:58], blk[33:26]};

  for (genvar l = 0; l < LANE_N; l++) begin : g_lane
    assign lane_hit[l] = (blk[25:2] == AM_ENC[l]) && (blk[57:34] == ~AM_ENC[l]);
  end

  // encodings are disjoint, so at most one lane can match
  always_comb begin
    hit_lane = '0;
    for (int l = LANE_N - 1; l >= 0; l--)
      if (lane_hit[l]) hit_lane = LANE_W'(l);
  end

  assign hit = ctrl && (|lane_hit);

endmodule

// File: rtl/am_lock_lane_rx.sv
// Per-lane AM lock: finds an AM, confirms it one period later, then marks
// every AM slot for deskew until four consecutive bad AMs are seen.
module am_lock_lane_rx
  import pcs_am_pkg::*;
#(
  parameter int BLOCK_W    = BLOCK_W_DEF,
  parameter int LANE_N     = LANE_N_DEF,
  parameter int AM_GAP_N   = 16383,
  parameter int GAP_CNT_W  = $clog2(AM_GAP_N + 1),
  parameter int BAD_AM_MAX = 4,
  parameter int LANE_W     = $clog2(LANE_N)
) (
  input logic             clk,
  input logic             reset,
  am_lock_lane_rx_if.slave bus
);

  localparam int BAD_W = $clog2(BAD_AM_MAX + 1);

  state_t               state;
  logic [LANE_W-1:0]    cand_lane;
  logic [GAP_CNT_W-1:0] gap_cnt;
  logic [BAD_W-1:0]     bad_cnt;
  logic [BAD_W-1:0]     bad_nxt;

  logic                 hit;
  logic [LANE_W-1:0]    hit_lane;
  logic                 slot;
  logic                 good;

  am_match_rx #(
    .BLOCK_W (BLOCK_W),
    .LANE_N  (LANE_N),
    .LANE_W  (LANE_W)
  ) u_match (
    .blk      (bus.data_i),
    .hit      (hit),
    .hit_lane (hit_lane)
  );

  assign slot    = (gap_cnt == GAP_CNT_W'(AM_GAP_N));
  assign good    = hit && (hit_lane == cand_lane);
  assign bad_nxt = bad_cnt + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= FIND;
      cand_lane     <= '0;
      gap_cnt       <= '0;
      bad_cnt       <= '0;
      bus.data_v_o  <= 1'b0;
      bus.data_o    <= '0;
      bus.am_v_o    <= 1'b0;
      bus.am_lock_o <= 1'b0;
      bus.lane_o    <= '0;
    end else begin
      bus.data_v_o <= bus.block_v_i;
      bus.data_o   <= bus.data_i;
      bus.am_v_o   <= 1'b0;
      if (!bus.block_lock_i) begin
        state         <= FIND;
        gap_cnt       <= '0;
        bad_cnt       <= '0;
        bus.am_lock_o <= 1'b0;
      end else if (bus.block_v_i) begin
        unique case (state)
          FIND: begin
            if (hit) begin
              cand_lane <= hit_lane;
              gap_cnt   <= '0;
              state     <= WAIT;
            end
          end
          WAIT: begin
            if (slot) begin
              gap_cnt <= '0;
              // a failed confirm drops to FIND without reusing this block
              if (good) begin
                state         <= LOCK;
                bad_cnt       <= '0;
                bus.am_lock_o <= 1'b1;
                bus.lane_o    <= cand_lane;
                bus.am_v_o    <= 1'b1;
              end else begin
                state <= FIND;
              end
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          LOCK: begin
            if (slot) begin
              gap_cnt <= '0;
              if (good) begin
                bad_cnt    <= '0;
                bus.am_v_o <= 1'b1;
              end else if (bad_nxt == BAD_W'(BAD_AM_MAX)) begin
                state         <= FIND;
                bad_cnt       <= '0;
                bus.am_lock_o <= 1'b0;
              end else begin
                // position is still trusted while the bad run is short
                bad_cnt    <= bad_nxt;
                bus.am_v_o <= 1'b1;
              end
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          default: state <= FIND;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_am_lock_lane_rx.sv
// Randomized scoreboard bench for am_lock_lane_rx with a behavioural model.
module tb_am_lock_lane_rx;
  import pcs_am_pkg::*;

  localparam int BW   = 66;
  localparam int LN   = 4;
  localparam int LW   = 2;
  localparam int GAP  = 7;
  localparam int BADM = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  am_lock_lane_rx_if #(.BLOCK_W(BW), .LANE_W(LW)) bus ();

  am_lock_lane_rx #(
    .BLOCK_W(BW), .LANE_N(LN), .AM_GAP_N(GAP), .BAD_AM_MAX(BADM)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic          dv;
    logic [BW-1:0] d;
    logic          amv;
    logic          lk;
    logic [LW-1:0] ln;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  logic [7:0] am_tab [4][3] = '{
    '{8'h90, 8'h76, 8'h47},
    '{8'hF0, 8'hC4, 8'hE6},
    '{8'hC5, 8'h65, 8'h9B},
    '{8'hA2, 8'h79, 8'h3D}
  };

  // model: mode 0 = searching, 1 = have candidate, 2 = locked
  int   mode = 0, since = 0, cand = 0, bads = 0;
  exp_t m;
  logic blk_lock = 1'b1;

  function automatic int ref_lane(input logic [BW-1:0] d);
    if (d[1:0] != 2'b01) return -1;
    for (int l = 0; l < 4; l++) begin
      bit ok = 1;
      for (int k = 0; k < 3; k++) begin
        if (d[8*k+2 +: 8] != am_tab[l][k]) ok = 0;
        if (d[8*(k+4)+2 +: 8] != ~am_tab[l][k]) ok = 0;
      end
      if (ok) return l;
    end
    return -1;
  endfunction

  function automatic logic [BW-1:0] rnd_blk();
    logic [BW-1:0] d;
    d[31:0]  = $urandom;
    d[63:32] = $urandom;
    d[65:64] = 2'($urandom);
    return d;
  endfunction

  function automatic logic [BW-1:0] mk_data();
    logic [BW-1:0] d;
    d = rnd_blk();
    d[1:0] = 2'b10;
    return d;
  endfunction

  function automatic logic [BW-1:0] mk_am(input int lane);
    logic [BW-1:0] d;
    d = rnd_blk();
    d[1:0] = 2'b01;
    for (int k = 0; k < 3; k++) begin
      d[8*k+2 +: 8]     = am_tab[lane][k];
      d[8*(k+4)+2 +: 8] = ~am_tab[lane][k];
    end
    return d;
  endfunction

  function automatic void model(input logic v, input logic bl, input logic [BW-1:0] d);
    int lane;
    m.dv  = v;
    m.d   = d;
    m.amv = 1'b0;
    if (!bl) begin
      mode = 0; since = 0; bads = 0; m.lk = 1'b0;
    end else if (v) begin
      lane = ref_lane(d);
      if (mode == 0) begin
        if (lane >= 0) begin mode = 1; cand = lane; since = 0; end
      end else begin
        since++;
        if (since == GAP + 1) begin
          since = 0;
          if (mode == 1) begin
            if (lane == cand) begin
              mode = 2; bads = 0; m.lk = 1'b1; m.ln = LW'(cand); m.amv = 1'b1;
            end else mode = 0;
          end else if (lane == cand) begin
            bads = 0; m.amv = 1'b1;
          end else begin
            bads++;
            if (bads == BADM) begin mode = 0; bads = 0; m.lk = 1'b0; end
            else m.amv = 1'b1;
          end
        end
      end
    end
  endfunction

  task automatic step(input logic v, input logic bl, input logic [BW-1:0] d);
    @(negedge clk);
    bus.block_v_i    = v;
    bus.block_lock_i = bl;
    bus.data_i       = d;
    model(v, bl, d);
    @(posedge clk);
    q.push_back(m);
  endtask

  task automatic send(input logic [BW-1:0] d, input bit bub);
    if (bub && $urandom_range(0, 2) == 0) step(1'b0, blk_lock, rnd_blk());
    step(1'b1, blk_lock, d);
  endtask

  // kind: 0 good AM, 1 corrupted AM, 2 no AM in the slot
  task automatic period(input int lane, input int kind, input bit bub);
    logic [BW-1:0] d;
    d = (kind == 2) ? mk_data() : mk_am(lane);
    if (kind == 1) d[34 + $urandom_range(0, 23)] ^= 1'b1;
    send(d, bub);
    for (int i = 0; i < GAP; i++) send(mk_data(), bub);
  endtask

  task automatic chk(input string nm, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " data_v_o"}, BW'(bus.data_v_o), '0);
    chk({tag, " data_o"}, bus.data_o, '0);
    chk({tag, " am_v_o"}, BW'(bus.am_v_o), '0);
    chk({tag, " am_lock_o"}, BW'(bus.am_lock_o), '0);
    chk({tag, " lane_o"}, BW'(bus.lane_o), '0);
  endtask

  function automatic void model_reset();
    mode = 0; since = 0; cand = 0; bads = 0;
    m = '{dv: 1'b0, d: '0, amv: 1'b0, lk: 1'b0, ln: '0};
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (bus.data_v_o !== e.dv || bus.am_v_o !== e.amv || bus.am_lock_o !== e.lk ||
            (e.lk && bus.lane_o !== e.ln) || (e.dv && bus.data_o !== e.d)) begin
          failures++;
          $display("FAIL out t=%0t: got dv=%b amv=%b lock=%b lane=%0d data=%h exp dv=%b amv=%b lock=%b lane=%0d data=%h",
                   $time, bus.data_v_o, bus.am_v_o, bus.am_lock_o, bus.lane_o, bus.data_o,
                   e.dv, e.amv, e.lk, e.ln, e.d);
        end
      end
    end
  end

  initial begin
    int w;
    model_reset();
    bus.block_v_i    = 1'b0;
    bus.block_lock_i = 1'b1;
    bus.data_i       = '0;
    #1 chk_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // lock to lane 2 and hold for a few periods
    repeat (3) step(1'b1, 1'b1, mk_data());
    repeat (4) period(2, 0, 0);

    // unlock, then a mismatched confirm followed by a clean lane-1 lock
    step(1'b1, 1'b0, mk_data());
    period(2, 0, 0);
    repeat (4) period(1, 0, 0);

    // three bad slots then a good one keeps lock; four bad slots drop it
    period(1, 1, 0); period(3, 0, 0); period(1, 2, 0); period(1, 0, 0);
    repeat (4) period(1, 1, 0);
    repeat (3) period(1, 0, 0);

    // bubbles in the block stream, lane 3
    step(1'b1, 1'b0, mk_data());
    repeat (6) period(3, 0, 1);

    // one-cycle block lock drop mid-LOCK, then relock
    repeat (3) step(1'b1, 1'b1, mk_data());
    step(1'b1, 1'b0, mk_data());
    period(3, 0, 0);
    repeat (3) period(3, 0, 0);

    // async reset between edges while in WAIT
    step(1'b1, 1'b0, mk_data());
    step(1'b1, 1'b1, mk_am(0));
    repeat (3) step(1'b1, 1'b1, mk_data());
    #3;
    q.delete();
    bus.block_v_i = 1'b0;
    reset = 1'b1;
    #1 chk_zero("async_reset");
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) period(0, 0, 0);

    // randomized soak on lane 2 with bubbles
    for (int i = 0; i < 24; i++) begin
      int r;
      r = $urandom_range(0, 9);
      period(2, (r < 6) ? 0 : ((r < 8) ? 1 : 2), 1'($urandom_range(0, 1)));
    end

    w = 0;
    while (q.size() > 0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/am_lock_lane_rx.md
Name: am_lock_lane_rx

Overview:
Per-lane alignment-marker (AM) lock stage for the 40GBASE-R multi-lane receive path. It sits between per-lane block lock and per-lane deskew. It searches the 66-bit block stream for a valid AM, identifies which PCS lane the stream carries, and acquires lock after two AMs spaced exactly one AM period apart. Once locked, it flags every AM position with a single-cycle pulse; deskew resets its skew counter on that pulse. Lock drops after four consecutive bad AMs.

Parameters:
BLOCK_W, 66, block width including 2-bit sync header
LANE_N, 4, number of PCS lanes
AM_GAP_N, 16383, data blocks between two consecutive AMs (AM period = AM_GAP_N+1 valid blocks); benches use small values
GAP_CNT_W, $clog2(AM_GAP_N+1), period counter width
BAD_AM_MAX, 4, consecutive bad AMs before lock is lost
LANE_W, $clog2(LANE_N), lane id width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
block_v_i  in  1  data_i carries a valid block this cycle
block_lock_i  in  1  upstream sync-header block lock held
data_i  in  BLOCK_W  received block; data_i[1:0] is the sync header, data_i[9:2] is M0, byte k at [8k+9:8k+2]
data_v_o  out  1  registered block_v_i
data_o  out  BLOCK_W  registered data_i
am_v_o  out  1  data_o is an AM at its expected position while locked
am_lock_o  out  1  AM lock held
lane_o  out  LANE_W  detected PCS lane id; valid while am_lock_o=1

Behaviour:
- Reset (async assert): FSM=FIND; counters=0; data_v_o=0, data_o=0, am_v_o=0, am_lock_o=0, lane_o=0. Deassertion is synchronous to clk.
- Latency is 1 cycle. data_o, data_v_o, am_v_o, am_lock_o and lane_o are registered and mutually aligned.
- Block state advances only on cycles with block_v_i=1. When block_v_i=0, all state holds and am_v_o=0.
- AM match (combinational) requires all of the following:
  - data_i[1:0]==2'b01 (control header).
  - M0,M1,M2 equal one lane's encoding: lane0 90/76/47, lane1 F0/C4/E6, lane2 C5/65/9B, lane3 A2/79/3D.
  - M4,M5,M6 equal the bitwise complements of M0,M1,M2.
  - BIP3 and BIP7 are ignored.
  - The match produces hit and hit_lane.
- FSM:
  - FIND: on hit, capture cand_lane=hit_lane, gap_cnt=0, go to WAIT.
  - WAIT: on each valid block, gap_cnt++. The valid block with gap_cnt==AM_GAP_N is the compare slot.
  - WAIT compare slot: hit and hit_lane==cand_lane -> go to LOCK, am_lock_o=1, lane_o=cand_lane, am_v_o=1 on this block. Otherwise go to FIND; that same block is not re-evaluated as a first AM.
  - LOCK: gap_cnt wraps from AM_GAP_N to 0 at each compare slot.
  - LOCK good slot (hit and lane matches): am_v_o=1, bad_cnt=0.
  - LOCK bad slot (no hit, or a different lane): bad_cnt++, am_v_o=1 still asserted (position is trusted), data forwarded unchanged.
  - LOCK, bad_cnt reaching BAD_AM_MAX: go to FIND, am_lock_o=0 on that same output cycle, am_v_o=0.
- A hit outside the compare slot is ignored in WAIT and LOCK.
- block_lock_i=0 in any state: next state FIND, counters cleared, am_lock_o=0 and am_v_o=0 from the next output cycle. This takes priority over all other events.
- gap_cnt never exceeds AM_GAP_N; bad_cnt saturates at BAD_AM_MAX.

Decomposition:
- Package pcs_am_pkg:
  - AM byte encodings per lane as constants.
  - Sync header constants.
  - BLOCK_W and LANE_N defaults.
  - FSM state enum: FIND, WAIT, LOCK.
- One sub-module, am_match_rx: combinational; input is a block, outputs are hit and hit_lane. It is reused by the lane reorder logic.

Test Plan:
- AM_GAP_N=7, lane2 AMs every 8 blocks, block_lock_i=1 -> am_lock_o rises with the second AM, 1 cycle after its input; lane_o=2; am_v_o pulses every 8 valid blocks afterwards.
- Second AM carries the lane1 pattern -> stay unlocked, return to FIND; the next two lane1 AMs 8 blocks apart -> lock with lane_o=1.
- While locked, corrupt 3 consecutive AMs then send a good one -> lock held, am_v_o on all 4 slots, bad_cnt cleared. Corrupt 4 consecutive AMs -> am_lock_o falls on the 4th slot output.
- Insert random block_v_i=0 bubbles between blocks -> AM slot positions counted in valid blocks only, lock retained, data_o/data_v_o match the input delayed by 1 cycle.
- Drop block_lock_i for 1 cycle mid-LOCK -> am_lock_o=0 next cycle; relock after two good AMs.
- Assert reset asynchronously mid-WAIT (between clock edges) -> all outputs 0 immediately; state FIND after release.
